// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays a 3-bit change code out as spaced dime/nickel eject pulses,
//            tracks hopper inventory, and reports completion and shortfall.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
  parameter int NICKEL_INIT = 8,
  parameter int DIME_INIT   = 8,
  parameter int CNT_W       = 4,
  parameter int EJECT_GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_change,
  input  logic             refill,
  output logic             nickel_out,
  output logic             dime_out,
  output logic             done,
  output logic             short,
  output logic             busy,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt
);

  // State encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_eject = 2'd1;
  localparam logic [1:0] c_st_gap   = 2'd2;

  // Gap counter runs 0 .. EJECT_GAP-1; keep at least one bit so it always exists
  localparam int              c_gap_w    = (EJECT_GAP > 1) ? $clog2(EJECT_GAP) : 1;
  localparam logic [c_gap_w-1:0] c_gap_last = (EJECT_GAP > 0) ? c_gap_w'(EJECT_GAP - 1) : '0;

  localparam logic [CNT_W-1:0] c_nickel_init = CNT_W'(NICKEL_INIT);
  localparam logic [CNT_W-1:0] c_dime_init   = CNT_W'(DIME_INIT);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [2:0]         r_rem;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic [CNT_W-1:0]   r_nickel_cnt;
  logic [CNT_W-1:0]   r_dime_cnt;

  logic               w_accept;
  logic [2:0]         w_code_val;
  logic               w_use_dime;
  logic               w_use_nickel;
  logic               w_finish;

  // Request handshake and code decoding; codes above 4 collapse to zero
  assign w_accept   = req_valid && (r_state == c_st_idle);
  assign w_code_val = (req_change <= 3'd4) ? req_change : 3'd0;

  // Coin selection: dimes first whenever two or more steps are still owed
  assign w_use_dime   = (r_state == c_st_eject) && (r_rem >= 3'd2) && (r_dime_cnt != '0);
  assign w_use_nickel = (r_state == c_st_eject) && !w_use_dime &&
                        (r_rem >= 3'd1) && (r_nickel_cnt != '0);
  assign w_finish     = (r_state == c_st_eject) && !w_use_dime && !w_use_nickel;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_next_state = c_st_eject;
        end
      end
      c_st_eject: begin
        if (w_finish) begin
          w_next_state = c_st_idle;
        end else if (EJECT_GAP == 0) begin
          w_next_state = c_st_eject;
        end else begin
          w_next_state = c_st_gap;
        end
      end
      c_st_gap: begin
        if (r_gap_cnt == c_gap_last) begin
          w_next_state = c_st_eject;
        end
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  // Output decode, purely from registered state so reset clears outputs at once
  always_comb begin
    req_ready  = (r_state == c_st_idle);
    busy       = (r_state != c_st_idle);
    dime_out   = w_use_dime;
    nickel_out = w_use_nickel;
    done       = w_finish;
    short      = w_finish && (r_rem != 3'd0);
    nickel_cnt = r_nickel_cnt;
    dime_cnt   = r_dime_cnt;
  end

  // Amount owed, inventory and gap spacing; refill lands before an accepted request pays
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem        <= 3'd0;
      r_gap_cnt    <= '0;
      r_nickel_cnt <= c_nickel_init;
      r_dime_cnt   <= c_dime_init;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_gap_cnt <= '0;
          if (refill) begin
            r_nickel_cnt <= c_nickel_init;
            r_dime_cnt   <= c_dime_init;
          end
          if (w_accept) begin
            r_rem <= w_code_val;
          end
        end
        c_st_eject: begin
          r_gap_cnt <= '0;
          if (w_use_dime) begin
            r_rem      <= r_rem - 3'd2;
            r_dime_cnt <= r_dime_cnt - CNT_W'(1);
          end else if (w_use_nickel) begin
            r_rem        <= r_rem - 3'd1;
            r_nickel_cnt <= r_nickel_cnt - CNT_W'(1);
          end else begin
            r_rem <= 3'd0;
          end
        end
        c_st_gap: begin
          r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
        end
        default: begin
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Directed self-checking bench for change_dispenser, using four
//            instances: default, no dimes, no nickels, and zero eject gap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       a_req_valid = 1'b0, a_refill = 1'b0;
  logic [2:0] a_req_change = 3'd0;
  logic       a_req_ready, a_nickel_out, a_dime_out, a_done, a_short, a_busy;
  logic [3:0] a_nickel_cnt, a_dime_cnt;
  // Instance D: DIME_INIT = 0
  logic       d_req_valid = 1'b0, d_refill = 1'b0;
  logic [2:0] d_req_change = 3'd0;
  logic       d_req_ready, d_nickel_out, d_dime_out, d_done, d_short, d_busy;
  logic [3:0] d_nickel_cnt, d_dime_cnt;
  // Instance N: NICKEL_INIT = 0
  logic       n_req_valid = 1'b0, n_refill = 1'b0;
  logic [2:0] n_req_change = 3'd0;
  logic       n_req_ready, n_nickel_out, n_dime_out, n_done, n_short, n_busy;
  logic [3:0] n_nickel_cnt, n_dime_cnt;
  // Instance G: EJECT_GAP = 0
  logic       g_req_valid = 1'b0, g_refill = 1'b0;
  logic [2:0] g_req_change = 3'd0;
  logic       g_req_ready, g_nickel_out, g_dime_out, g_done, g_short, g_busy;
  logic [3:0] g_nickel_cnt, g_dime_cnt;

  change_dispenser u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_change(a_req_change), .refill(a_refill), .nickel_out(a_nickel_out),
    .dime_out(a_dime_out), .done(a_done), .short(a_short), .busy(a_busy),
    .nickel_cnt(a_nickel_cnt), .dime_cnt(a_dime_cnt)
  );

  change_dispenser #(.DIME_INIT(0)) u_d (
    .clk(clk), .rst_n(rst_n), .req_valid(d_req_valid), .req_ready(d_req_ready),
    .req_change(d_req_change), .refill(d_refill), .nickel_out(d_nickel_out),
    .dime_out(d_dime_out), .done(d_done), .short(d_short), .busy(d_busy),
    .nickel_cnt(d_nickel_cnt), .dime_cnt(d_dime_cnt)
  );

  change_dispenser #(.NICKEL_INIT(0)) u_n (
    .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_change(n_req_change), .refill(n_refill), .nickel_out(n_nickel_out),
    .dime_out(n_dime_out), .done(n_done), .short(n_short), .busy(n_busy),
    .nickel_cnt(n_nickel_cnt), .dime_cnt(n_dime_cnt)
  );

  change_dispenser #(.EJECT_GAP(0)) u_g (
    .clk(clk), .rst_n(rst_n), .req_valid(g_req_valid), .req_ready(g_req_ready),
    .req_change(g_req_change), .refill(g_refill), .nickel_out(g_nickel_out),
    .dime_out(g_dime_out), .done(g_done), .short(g_short), .busy(g_busy),
    .nickel_cnt(g_nickel_cnt), .dime_cnt(g_dime_cnt)
  );

  // Vector layout used below: {busy, dime_out, nickel_out, done, short}

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({a_req_ready, a_busy, a_dime_out, a_nickel_out, a_done, a_short} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 100000",
               {a_req_ready, a_busy, a_dime_out, a_nickel_out, a_done, a_short});
    end
    checks++;
    if ({a_nickel_cnt, a_dime_cnt} !== {4'd8, 4'd8}) begin
      errors++;
      $display("FAIL reset_counts: got n=%0d d=%0d expected n=8 d=8", a_nickel_cnt, a_dime_cnt);
    end
    checks++;
    if ({d_nickel_cnt, d_dime_cnt} !== {4'd8, 4'd0}) begin
      errors++;
      $display("FAIL reset_counts_nodime: got n=%0d d=%0d expected n=8 d=0", d_nickel_cnt, d_dime_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_code011();
    logic [4:0] exp;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_change = 3'b011;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      exp = (cyc == 1) ? 5'b11000 : (cyc == 4) ? 5'b10100 : (cyc == 7) ? 5'b10010 : 5'b10000;
      checks++;
      if ({a_busy, a_dime_out, a_nickel_out, a_done, a_short} !== exp) begin
        errors++;
        $display("FAIL code011_cycle%0d: got %b expected %b", cyc,
                 {a_busy, a_dime_out, a_nickel_out, a_done, a_short}, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({a_req_ready, a_nickel_cnt, a_dime_cnt} !== {1'b1, 4'd7, 4'd7}) begin
      errors++;
      $display("FAIL code011_after: got ready=%b n=%0d d=%0d expected ready=1 n=7 d=7",
               a_req_ready, a_nickel_cnt, a_dime_cnt);
    end
  endtask

  task automatic test_zero_codes();
    logic [2:0] codes [2];
    codes[0] = 3'b000;
    codes[1] = 3'b111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_req_valid = 1'b1; a_req_change = codes[i];
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_busy, a_dime_out, a_nickel_out, a_done, a_short} !== 5'b10010) begin
        errors++;
        $display("FAIL zero_code%b_done: got %b expected 10010", codes[i],
                 {a_busy, a_dime_out, a_nickel_out, a_done, a_short});
      end
      @(negedge clk);
      checks++;
      if ({a_req_ready, a_dime_out, a_nickel_out, a_done, a_nickel_cnt, a_dime_cnt} !==
          {1'b1, 3'b000, 4'd7, 4'd7}) begin
        errors++;
        $display("FAIL zero_code%b_after: got ready=%b pulses=%b n=%0d d=%0d expected ready=1 pulses=000 n=7 d=7",
                 codes[i], a_req_ready, {a_dime_out, a_nickel_out, a_done}, a_nickel_cnt, a_dime_cnt);
      end
    end
  endtask

  task automatic test_dime_empty();
    logic [4:0] exp;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_change = 3'b100;
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      exp = (cyc == 1 || cyc == 4 || cyc == 7 || cyc == 10) ? 5'b10100 :
            (cyc == 13) ? 5'b10010 : 5'b10000;
      checks++;
      if ({d_busy, d_dime_out, d_nickel_out, d_done, d_short} !== exp) begin
        errors++;
        $display("FAIL nodime_cycle%0d: got %b expected %b", cyc,
                 {d_busy, d_dime_out, d_nickel_out, d_done, d_short}, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({d_req_ready, d_nickel_cnt, d_dime_cnt} !== {1'b1, 4'd4, 4'd0}) begin
      errors++;
      $display("FAIL nodime_after: got ready=%b n=%0d d=%0d expected ready=1 n=4 d=0",
               d_req_ready, d_nickel_cnt, d_dime_cnt);
    end
  endtask

  task automatic test_nickel_empty();
    logic [4:0] exp;
    @(negedge clk);
    n_req_valid = 1'b1; n_req_change = 3'b011;
    @(posedge clk); #1;
    n_req_valid = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      exp = (cyc == 1) ? 5'b11000 : (cyc == 4) ? 5'b10011 : 5'b10000;
      checks++;
      if ({n_busy, n_dime_out, n_nickel_out, n_done, n_short} !== exp) begin
        errors++;
        $display("FAIL nonickel_cycle%0d: got %b expected %b", cyc,
                 {n_busy, n_dime_out, n_nickel_out, n_done, n_short}, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({n_req_ready, n_short, n_nickel_cnt, n_dime_cnt} !== {1'b1, 1'b0, 4'd0, 4'd7}) begin
      errors++;
      $display("FAIL nonickel_after: got ready=%b short=%b n=%0d d=%0d expected ready=1 short=0 n=0 d=7",
               n_req_ready, n_short, n_nickel_cnt, n_dime_cnt);
    end
  endtask

  task automatic test_back_to_back_gap0();
    logic [4:0] exp;
    @(negedge clk);
    g_req_valid = 1'b1; g_req_change = 3'b100;
    @(posedge clk); #1;
    g_req_valid = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      exp = (cyc <= 2) ? 5'b11000 : (cyc == 3) ? 5'b10010 : 5'b00000;
      checks++;
      if ({g_busy, g_dime_out, g_nickel_out, g_done, g_short} !== exp) begin
        errors++;
        $display("FAIL gap0_cycle%0d: got %b expected %b", cyc,
                 {g_busy, g_dime_out, g_nickel_out, g_done, g_short}, exp);
      end
      // A request presented while busy must be dropped, not queued
      if (cyc == 2) begin
        g_req_valid = 1'b1; g_req_change = 3'b010;
      end else begin
        g_req_valid = 1'b0;
      end
    end
    checks++;
    if ({g_req_ready, g_nickel_cnt, g_dime_cnt} !== {1'b1, 4'd8, 4'd6}) begin
      errors++;
      $display("FAIL gap0_after: got ready=%b n=%0d d=%0d expected ready=1 n=8 d=6",
               g_req_ready, g_nickel_cnt, g_dime_cnt);
    end
  endtask

  task automatic test_reset_mid_payout();
    logic [4:0] exp;
    @(negedge clk);
    a_refill = 1'b1;
    @(posedge clk); #1;
    a_refill = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      a_req_valid = 1'b1; a_req_change = 3'b010;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      repeat (5) @(negedge clk);
    end
    checks++;
    if ({a_req_ready, a_dime_cnt} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL drain_dimes: got ready=%b d=%0d expected ready=1 d=5", a_req_ready, a_dime_cnt);
    end
    @(negedge clk);
    a_req_valid = 1'b1; a_req_change = 3'b100;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_busy, a_dime_out, a_nickel_out, a_done} !== 4'b1100) begin
      errors++;
      $display("FAIL midpay_first_dime: got %b expected 1100", {a_busy, a_dime_out, a_nickel_out, a_done});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_req_ready, a_busy, a_dime_out, a_nickel_out, a_done, a_short, a_nickel_cnt, a_dime_cnt} !==
        {6'b100000, 4'd8, 4'd8}) begin
      errors++;
      $display("FAIL midpay_reset: got ready=%b busy=%b pulses=%b n=%0d d=%0d expected ready=1 busy=0 pulses=0000 n=8 d=8",
               a_req_ready, a_busy, {a_dime_out, a_nickel_out, a_done, a_short}, a_nickel_cnt, a_dime_cnt);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if ({a_busy, a_dime_out, a_nickel_out, a_done} !== 4'b0000) begin
        errors++;
        $display("FAIL midpay_held%0d: got %b expected 0000", cyc, {a_busy, a_dime_out, a_nickel_out, a_done});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    a_refill = 1'b1; a_req_valid = 1'b1; a_req_change = 3'b010;
    @(posedge clk); #1;
    a_refill = 1'b0; a_req_valid = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      exp = (cyc == 1) ? 5'b11000 : (cyc == 4) ? 5'b10010 : 5'b10000;
      checks++;
      if ({a_busy, a_dime_out, a_nickel_out, a_done, a_short} !== exp) begin
        errors++;
        $display("FAIL refill_req_cycle%0d: got %b expected %b", cyc,
                 {a_busy, a_dime_out, a_nickel_out, a_done, a_short}, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({a_req_ready, a_nickel_cnt, a_dime_cnt} !== {1'b1, 4'd8, 4'd7}) begin
      errors++;
      $display("FAIL refill_req_after: got ready=%b n=%0d d=%0d expected ready=1 n=8 d=7",
               a_req_ready, a_nickel_cnt, a_dime_cnt);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_code011();
    test_zero_codes();
    test_dime_empty();
    test_nickel_empty();
    test_back_to_back_gap0();
    test_reset_mid_payout();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
